// File: rtl/offload_pipe.sv
// rtl/offload_pipe.sv - elastic AXI-S offload pipeline: validate, unpack, per-beat op, repack
// Malformed beats are consumed and counted but never enter the stage chain.
module offload_pipe #(
  parameter int REG_SIZE       = 32,
  parameter int DATA_WORDS     = 16,
  parameter int NUM_REGS       = 14,
  parameter int PIPELINE_DEPTH = 3,
  parameter logic [REG_SIZE-1:0] PKT_MAGIC = 32'h0FFA0FFB,
  parameter int CNT_W          = 16,
  localparam int TDATA_W       = DATA_WORDS * REG_SIZE,
  localparam int KEEP_W        = TDATA_W / 8,
  localparam int RW            = NUM_REGS * REG_SIZE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         op_mode,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [TDATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0]  s_axis_tkeep,
  input  logic               s_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [TDATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0]  m_axis_tkeep,
  output logic               m_axis_tlast,
  output logic [CNT_W-1:0]   cnt_ok,
  output logic [CNT_W-1:0]   cnt_drop,
  output logic [3:0]         dbg
);

  localparam int PD = PIPELINE_DEPTH;

  logic [PD-1:0]    valid_q, valid_d;
  logic [PD-1:0]    last_q, last_d;
  logic [RW-1:0]    regs_q [PD];
  logic [RW-1:0]    regs_d [PD];
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d;
  logic [CNT_W-1:0] cnt_drop_q, cnt_drop_d;
  logic             drop_seen_q, drop_seen_d;
  logic [PD-1:0]    ready;
  logic             accept;
  logic             good;
  logic             unused_pad;

  function automatic logic [RW-1:0] apply_op(input logic [RW-1:0] r, input logic [1:0] op);
    logic [RW-1:0]       res;
    logic [REG_SIZE-1:0] w;
    logic [REG_SIZE-1:0] o;
    res = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w = r[i*REG_SIZE +: REG_SIZE];
      o = '0;
      case (op)
        2'b00: o = w;
        2'b01: for (int b = 0; b < REG_SIZE/8; b++) o[8*b +: 8] = w[REG_SIZE-8-8*b +: 8];
        2'b10: o = w + REG_SIZE'(1);
        default: o = ~w;
      endcase
      res[i*REG_SIZE +: REG_SIZE] = o;
    end
    return res;
  endfunction

  // A stage can load when it is empty or everything downstream of it can move.
  always_comb begin
    logic r;
    r = m_axis_tready;
    for (int k = PD-1; k >= 0; k--) begin
      r        = r | !valid_q[k];
      ready[k] = r;
    end
  end

  assign s_axis_tready = ready[0] && !reset;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign good          = (&s_axis_tkeep) && (s_axis_tdata[TDATA_W-1 -: REG_SIZE] == PKT_MAGIC);

  generate
    if (RW < TDATA_W - REG_SIZE) begin : g_pad
      assign unused_pad = ^s_axis_tdata[TDATA_W-REG_SIZE-1:RW];
    end else begin : g_nopad
      assign unused_pad = 1'b0;
    end
  endgenerate

  always_comb begin
    valid_d     = valid_q;
    last_d      = last_q;
    regs_d      = regs_q;
    op_d        = op_q;
    cnt_ok_d    = cnt_ok_q;
    cnt_drop_d  = cnt_drop_q;
    drop_seen_d = drop_seen_q;

    if (ready[0]) begin
      valid_d[0] = accept && good;
      if (accept && good) begin
        regs_d[0] = s_axis_tdata[RW-1:0];
        op_d      = op_mode;
        last_d[0] = s_axis_tlast;
      end
    end

    // Stage 1 applies the captured op; later stages only delay.
    for (int k = 1; k < PD; k++) begin
      if (ready[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          regs_d[k] = (k == 1) ? apply_op(regs_q[0], op_q) : regs_q[k-1];
          last_d[k] = last_q[k-1];
        end
      end
    end

    if (accept && good && (cnt_ok_q != '1)) cnt_ok_d = cnt_ok_q + CNT_W'(1);
    if (accept && !good) begin
      drop_seen_d = 1'b1;
      if (cnt_drop_q != '1) cnt_drop_d = cnt_drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      last_q      <= '0;
      op_q        <= '0;
      cnt_ok_q    <= '0;
      cnt_drop_q  <= '0;
      drop_seen_q <= 1'b0;
      for (int k = 0; k < PD; k++) regs_q[k] <= '0;
    end else begin
      valid_q     <= valid_d;
      last_q      <= last_d;
      op_q        <= op_d;
      cnt_ok_q    <= cnt_ok_d;
      cnt_drop_q  <= cnt_drop_d;
      drop_seen_q <= drop_seen_d;
      for (int k = 0; k < PD; k++) regs_q[k] <= regs_d[k];
    end
  end

  always_comb begin
    m_axis_tdata = '0;
    if (valid_q[PD-1]) begin
      m_axis_tdata[RW-1:0]               = regs_q[PD-1];
      m_axis_tdata[TDATA_W-1 -: REG_SIZE] = PKT_MAGIC;
    end
  end

  assign m_axis_tvalid = valid_q[PD-1];
  assign m_axis_tkeep  = valid_q[PD-1] ? '1 : '0;
  assign m_axis_tlast  = valid_q[PD-1] & last_q[PD-1];
  assign cnt_ok        = cnt_ok_q;
  assign cnt_drop      = cnt_drop_q;
  assign dbg           = {drop_seen_q, m_axis_tvalid && !m_axis_tready, |valid_q, m_axis_tvalid};

endmodule

// File: tb/tb_offload_pipe.sv
// tb/tb_offload_pipe.sv - randomized and directed bench for offload_pipe against a queue model
module tb_offload_pipe;
  localparam int RS = 32, DW = 16, NR = 14, PD = 3, CW = 4;
  localparam int TW = DW * RS, KW = TW / 8;
  localparam logic [RS-1:0] MAGIC = 32'h0FFA0FFB;

  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] op_mode = 2'b00;
  logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [TW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic m_tvalid, m_tready = 1'b0, m_tlast;
  logic [TW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [CW-1:0] cnt_ok, cnt_drop;
  logic [3:0] dbg;

  offload_pipe #(.REG_SIZE(RS), .DATA_WORDS(DW), .NUM_REGS(NR), .PIPELINE_DEPTH(PD),
                 .PKT_MAGIC(MAGIC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .op_mode(op_mode),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .cnt_ok(cnt_ok), .cnt_drop(cnt_drop), .dbg(dbg));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, out_cnt = 0, acc_cyc = 0, out_cyc = 0;
  int m_mode = 0, pat = 0;
  bit armed = 0, acc_flag = 0, prev_stall = 0;
  logic [TW-1:0] exp_q[$];
  logic exp_last_q[$];
  int m_ok = 0, m_drop = 0;
  bit m_drop_seen = 0;
  logic [TW-1:0] prev_data, last_data;
  logic prev_last, last_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_wide(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] model_out(input logic [TW-1:0] din, input logic [1:0] op);
    logic [TW-1:0] r;
    logic [RS-1:0] w, v;
    r = '0;
    for (int i = 0; i < NR; i++) begin
      w = din[i*RS +: RS];
      case (op)
        2'd0: v = w;
        2'd1: v = {w[7:0], w[15:8], w[23:16], w[31:24]};
        2'd2: v = w + 32'd1;
        default: v = ~w;
      endcase
      r[i*RS +: RS] = v;
    end
    r[TW-1 -: RS] = MAGIC;
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1;
    case (m_mode)
      0: m_tready = 1'b1;
      1: begin m_tready = (pat % 4 == 0) || (pat % 4 == 3); pat++; end
      2: m_tready = 1'b0;
      default: m_tready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Compare process: DUT against model state reflecting all edges so far.
  always @(negedge clk) begin
    if (armed) begin
      chk("cnt_ok", 32'(cnt_ok), 32'(m_ok));
      chk("cnt_drop", 32'(cnt_drop), 32'(m_drop));
      chk("drop_seen", 32'(dbg[3]), 32'(m_drop_seen));
      chk("stall", 32'(dbg[2]), 32'(m_tvalid && !m_tready));
      chk("busy", 32'(dbg[1]), 32'(exp_q.size() != 0));
      chk("dbg_valid", 32'(dbg[0]), 32'(m_tvalid));
      chk("s_tready", 32'(s_tready), 32'(!reset && (m_tready || exp_q.size() < PD)));
      if (m_tvalid && exp_q.size() == 0) chk("stale_beat", 32'(m_tvalid), 32'd0);
      if (prev_stall) begin
        chk("hold_valid", 32'(m_tvalid), 32'd1);
        chk_wide("hold_data", m_tdata, prev_data);
        chk("hold_last", 32'(m_tlast), 32'(prev_last));
      end
    end
    acc_flag = 0;
    if (reset) begin
      exp_q.delete(); exp_last_q.delete();
      m_ok = 0; m_drop = 0; m_drop_seen = 0;
      armed = 1;
      prev_stall = 0;
    end else begin
      if (m_tvalid && m_tready && exp_q.size() != 0) begin
        chk_wide("out_data", m_tdata, exp_q.pop_front());
        chk("out_last", 32'(m_tlast), 32'(exp_last_q.pop_front()));
        chk("out_keep", 32'(&m_tkeep), 32'd1);
        out_cnt++; out_cyc = cyc; last_data = m_tdata; last_last = m_tlast;
      end
      if (s_tvalid && s_tready) begin
        acc_flag = 1; acc_cyc = cyc;
        if ((&s_tkeep) && s_tdata[TW-1 -: RS] == MAGIC) begin
          exp_q.push_back(model_out(s_tdata, op_mode));
          exp_last_q.push_back(s_tlast);
          if (m_ok != 15) m_ok++;
        end else begin
          if (m_drop != 15) m_drop++;
          m_drop_seen = 1;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data = m_tdata; prev_last = m_tlast;
    end
  end

  task automatic send(input logic [TW-1:0] d, input logic [KW-1:0] k, input logic l, input logic [1:0] op);
    bit done;
    done = 0;
    s_tvalid = 1; s_tdata = d; s_tkeep = k; s_tlast = l; op_mode = op;
    for (int t = 0; t < 200 && !done; t++) begin
      @(posedge clk);
      if (acc_flag) done = 1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    #1;
    s_tvalid = 0;
  endtask

  task automatic wait_out(input int target);
    bit done;
    done = 0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk); #1;
      if (out_cnt >= target) done = 1;
    end
    if (!done) chk("wait_out_timeout", 32'(out_cnt), 32'(target));
  endtask

  task automatic do_reset();
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1; reset = 0;
  endtask

  function automatic logic [TW-1:0] mk_beat(input logic [RS-1:0] w0);
    logic [TW-1:0] d;
    for (int i = 0; i < DW; i++) d[i*RS +: RS] = $urandom;
    d[RS-1:0] = w0;
    d[TW-1 -: RS] = MAGIC;
    return d;
  endfunction

  logic [TW-1:0] d;
  logic [RS-1:0] op_in [4] = '{32'h11223344, 32'h11223344, 32'h11223344, 32'hFFFFFFFF};
  logic [1:0]    op_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
  logic [RS-1:0] op_exp [4] = '{32'h44332211, 32'h11223345, 32'hEEDDCCBB, 32'h00000000};
  int base;

  initial begin
    repeat (3) @(posedge clk);
    #1; reset = 0;
    @(negedge clk); #1;
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_cnt_ok", 32'(cnt_ok), 32'd0);
    chk("rst_dbg", 32'(dbg), 32'd0);
    chk_wide("rst_m_tdata", m_tdata, '0);

    // Single good beat, latency and packing
    m_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < DW; i++) d[i*RS +: RS] = 32'(i);
    d[14*RS +: RS] = 32'hDEADBEEF;
    d[TW-1 -: RS] = MAGIC;
    send(d, '1, 1'b1, 2'd0);
    wait_out(1);
    chk("latency", 32'(out_cyc - acc_cyc), 32'd3);
    chk("w0", last_data[0 +: RS], 32'd0);
    chk("w13", last_data[13*RS +: RS], 32'd13);
    chk("w14", last_data[14*RS +: RS], 32'd0);
    chk("w15", last_data[15*RS +: RS], 32'h0FFA0FFB);
    chk("tlast1", 32'(last_last), 32'd1);
    chk("cnt_ok1", 32'(cnt_ok), 32'd1);

    // Op modes with hand-computed results
    for (int i = 0; i < 4; i++) begin
      base = out_cnt;
      @(posedge clk); #1;
      send(mk_beat(op_in[i]), '1, 1'b0, op_sel[i]);
      wait_out(base + 1);
      chk("op_word0", last_data[0 +: RS], op_exp[i]);
    end

    // Drops
    do_reset();
    base = out_cnt;
    send(mk_beat(32'h1), '1, 1'b0, 2'd0);
    d = mk_beat(32'h2); d[TW-1 -: RS] = 32'h0FFA0FFC;
    send(d, '1, 1'b1, 2'd0);
    send(mk_beat(32'h3), ~(KW'(1) << 5), 1'b1, 2'd0);
    repeat (8) @(posedge clk);
    @(negedge clk); #1;
    chk("drop_outs", 32'(out_cnt - base), 32'd1);
    chk("drop_cnt_ok", 32'(cnt_ok), 32'd1);
    chk("drop_cnt_drop", 32'(cnt_drop), 32'd2);
    chk("drop_dbg3", 32'(dbg[3]), 32'd1);

    // Backpressure pattern 1,0,0,1
    do_reset();
    base = out_cnt; m_mode = 1;
    for (int i = 0; i < 10; i++) send(mk_beat(32'(i)), '1, 1'(i == 9), 2'($urandom_range(0, 3)));
    wait_out(base + 10);
    chk("bp_outs", 32'(out_cnt - base), 32'd10);

    // Full pipeline behind a stall, then reset mid-stream
    do_reset();
    m_mode = 2;
    @(posedge clk); @(posedge clk); #1;
    base = out_cnt;
    for (int i = 0; i < 3; i++) send(mk_beat(32'(i)), '1, 1'b0, 2'd0);
    @(negedge clk); #1;
    chk("full_s_tready", 32'(s_tready), 32'd0);
    chk("full_m_tvalid", 32'(m_tvalid), 32'd1);
    do_reset();
    chk("mid_rst_valid", 32'(m_tvalid), 32'd0);
    chk("mid_rst_cnt", 32'(cnt_ok), 32'd0);
    m_mode = 0;
    repeat (10) @(posedge clk);
    chk("mid_rst_no_stale", 32'(out_cnt - base), 32'd0);

    // Saturation
    do_reset();
    for (int i = 0; i < 20; i++) send(mk_beat(32'(i)), '1, 1'b0, 2'd0);
    repeat (6) @(posedge clk);
    @(negedge clk); #1;
    chk("sat_cnt_ok", 32'(cnt_ok), 32'd15);

    // Randomized traffic
    do_reset();
    m_mode = 3;
    for (int n = 0; n < 300; n++) begin
      int kind;
      d = mk_beat($urandom);
      kind = $urandom_range(0, 5);
      if (kind == 0) d[TW-1 -: RS] = MAGIC ^ (32'd1 << $urandom_range(0, 31));
      send(d, (kind == 1) ? ~(KW'(1) << $urandom_range(0, KW-1)) : '1,
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    m_mode = 0;
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/offload_pipe.md
Name: offload_pipe

Overview:
- Parametrised successor to the single-beat AXI-S offload stage.
- Accepts fixed-format beats tagged with a magic word in the top word of tdata.
- Unpacks NUM_REGS registers, applies a per-beat selectable operation and repacks with the magic word.
- Unlike the previous generation, it is fully elastic (honours m_axis_tready at every stage), drops malformed beats, forwards tlast and keeps statistics.
- Sits between the DMA MM2S and S2MM streams in the offload datapath.

Parameters:
- REG_SIZE, 32, bits per register word.
- DATA_WORDS, 16, words per beat; TDATA_W = DATA_WORDS*REG_SIZE, KEEP_W = TDATA_W/8.
- NUM_REGS, 14, registers carried per beat; legal range 1..DATA_WORDS-1.
- PIPELINE_DEPTH, 3, register stages from input to output; legal range 2..8.
- PKT_MAGIC, 32'h0FFA0FFB, required value of word DATA_WORDS-1; REG_SIZE bits wide.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- op_mode  in  2  operation select, sampled with each accepted beat.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  TDATA_W  input beat.
- s_axis_tkeep  in  KEEP_W  byte enables.
- s_axis_tlast  in  1  end of packet.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  TDATA_W  output beat.
- m_axis_tkeep  out  KEEP_W  byte enables.
- m_axis_tlast  out  1  end of packet.
- cnt_ok  out  CNT_W  good beats accepted.
- cnt_drop  out  CNT_W  malformed beats discarded.
- dbg  out  4  {drop_seen, stall, busy, m_axis_tvalid}.

Behaviour:
- Reset: all stage valid bits and outputs are 0 from the cycle after reset is sampled high. This covers m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, cnt_ok, cnt_drop and dbg. s_axis_tready is 0 while reset is high.
- Reset mid-operation discards every in-flight beat; nothing is emitted for them.
- Pipeline: PIPELINE_DEPTH stages, each holding {valid, regs, op, last}.
  - ready_k = !valid_k || ready_(k+1); the last stage's downstream ready is m_axis_tready.
  - s_axis_tready = ready_0 (combinational from stage state and m_axis_tready); there are no bubbles when the output is always ready.
- Latency: a good beat accepted in cycle N appears on m_axis with m_axis_tvalid=1 in cycle N+PIPELINE_DEPTH, provided there is no backpressure.
- Sustained throughput is 1 beat/cycle.
- Beat validity: a beat is good iff s_axis_tkeep is all ones AND word DATA_WORDS-1 == PKT_MAGIC.
  - A malformed beat is accepted (it completes its handshake), never enters stage 0, increments cnt_drop and sets sticky drop_seen.
  - A tlast on a dropped beat is lost.
- Stage 0 captures regs[i] = s_axis_tdata word i for i=0..NUM_REGS-1. It also captures op_mode and tlast, and increments cnt_ok.
- Operation is applied in stage 1; remaining stages are pure delay. Per register:
  - 00: pass.
  - 01: byte-swap each REG_SIZE word.
  - 10: reg+1, wrapping modulo 2^REG_SIZE (all ones -> 0).
  - 11: bitwise NOT.
- op_mode changes take effect on the next accepted beat only; beats already in flight keep their captured op.
- Output packing:
  - Words 0..NUM_REGS-1 = processed regs.
  - Words NUM_REGS..DATA_WORDS-2 = 0.
  - Word DATA_WORDS-1 = PKT_MAGIC.
  - m_axis_tkeep is all ones.
  - m_axis_tlast = captured tlast.
- Handshake: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, tkeep and tlast hold stable. A valid beat is never withdrawn.
- Counters: cnt_ok and cnt_drop saturate at 2^CNT_W-1 and do not wrap.
- dbg:
  - stall = m_axis_tvalid && !m_axis_tready.
  - busy = any stage valid.
  - drop_seen is cleared only by reset.
- Full pipeline with m_axis_tready=0: s_axis_tready=0 and no input is consumed. When m_axis_tready returns to 1, the output beat and the input beat transfer in the same cycle.

Test Plan:
- Reset, then one good beat: regs words = 0..13, op=00, tlast=1, m_axis_tready=1 -> m_axis_tvalid is high exactly 3 cycles after acceptance. Output words 0..13 are unchanged, word 14 = 0, word 15 = 0x0FFA0FFB, tlast=1, cnt_ok=1.
- Op modes: word 0 = 0x11223344 sent with op=01, then 10, then 11 -> word 0 outputs 0x44332211, then 0x11223345, then 0xEEDDCCBB. A beat with word 0 = 0xFFFFFFFF and op=10 -> outputs 0x00000000.
- Drop: three beats good, bad magic (0x0FFA0FFC), good with tkeep bit 5 = 0 -> only 1 output beat, cnt_ok=1, cnt_drop=2, dbg[3]=1.
- Backpressure: stream 10 good beats with m_axis_tready toggling 1,0,0,1 -> all 10 beats emerge in order with data held stable during stalls. s_axis_tready=0 once 3 beats are buffered behind a stall.
- Reset mid-stream: assert reset for 1 cycle with 3 beats in flight -> m_axis_tvalid=0 the next cycle, no stale beats afterwards, counters = 0.
- Saturation with CNT_W=4: send 20 good beats -> cnt_ok holds at 15.
